pipe_hazard_ctrl: RTL

- Parametrised successor to the fixed hazard detector in the 16-bit five-stage core.
- Tracks in-flight register writes in a scoreboard shift register covering DEPTH post-decode stages.
- Generates stall, bubble, IF/ID flush and per-operand forwarding selects.
- Supports forwarding on/off mode, memory-busy freeze, pending branch redirect and stall/flush performance counters.
- Sits beside decode; drives the PC, IF_ID and ID_EX enables and the execute-stage operand muxes.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 38 +++
 rtl/pipe_hazard_ctrl_if.sv | 43 ++++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard entry layout,
// forwarding select encoding and the per-cycle priority state.
package pipe_hazard_ctrl_pkg;

  // Widest register address a scoreboard entry can hold; narrower address
  // buses are zero-extended into it.
  localparam int MAX_AW = 8;

  // Width of the post-redirect flush down-counter (FLUSH_CYCLES up to 7).
  localparam int FCNT_W = 3;

  // Forwarding select value meaning "take the operand from the register file".
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic              valid;
    logic [MAX_AW-1:0] addr;
    logic              is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, addr: '0, is_load: 1'b0};

  // Which rule owns the pipeline controls this cycle, highest priority first:
  // FREEZE (memory busy), FLUSH (redirect live, pending or still draining),
  // RAW_STALL, then RUN.
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    RAW_STALL = 2'd1,
    FREEZE    = 2'd2,
    FLUSH     = 2'd3
  } hz_state_e;

  // Scoreboard index i is forwarded with select value i+1 (0 is the regfile).
  function automatic int stage_to_sel(input int idx);
    return idx + 1;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side hazard bus: decoded operand info in, pipeline enables,
// forwarding selects and performance counters out.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 3,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic              id_rs_used;
  logic [REG_AW-1:0] id_rt;
  logic              id_rt_used;
  logic              id_wr_en;
  logic [REG_AW-1:0] id_wr_addr;
  logic              id_is_load;
  logic              redirect;
  logic              mem_busy;

  logic              pc_we;
  logic              if_id_we;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic [SEL_W-1:0]  fwd_a_sel;
  logic [SEL_W-1:0]  fwd_b_sel;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  // Core side: drives decode information, consumes the controls.
  modport master (
    output id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
           id_wr_en, id_wr_addr, id_is_load, redirect, mem_busy,
    input  pc_we, if_id_we, if_id_flush, id_ex_bubble,
           fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );

  // Hazard controller side.
  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used,
           id_wr_en, id_wr_addr, id_is_load, redirect, mem_busy,
    output pc_we, if_id_we, if_id_flush, id_ex_bubble,
           fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; holds at
// all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: step on inc unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: scoreboard of in-flight register writes over
// DEPTH post-decode stages, RAW stall / forwarding decisions, memory freeze,
// redirect flush sequencing and stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW       = 3,
  parameter int DEPTH        = 3,
  parameter int FWD_EN       = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16,
  parameter int SEL_W        = 2
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  hz
);

  sb_entry_t         sb_q [DEPTH];
  sb_entry_t         sb_d [DEPTH];
  logic              pend_q, pend_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic [REG_AW-1:0] rs_addr, rt_addr, wr_addr;
  logic              hit_a, hit_b, ld_a, ld_b;
  int                ya_i, yb_i;
  logic              stall_a, stall_b, raw_stall;
  logic              redir_acc;
  hz_state_e         state;

  logic              pc_we, if_id_we, if_id_flush, id_ex_bubble;
  logic [SEL_W-1:0]  fwd_a_sel, fwd_b_sel;
  logic              stall_inc, flush_inc;

  assign rs_addr = hz.id_rs;
  assign rt_addr = hz.id_rt;
  assign wr_addr = hz.id_wr_addr;

  // Youngest scoreboard match per source: scan oldest to youngest so the
  // lowest matching index is the one left standing.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    ld_a  = 1'b0;
    ld_b  = 1'b0;
    ya_i  = 0;
    yb_i  = 0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (sb_q[i].valid && (sb_q[i].addr == MAX_AW'(rs_addr)) &&
          hz.id_rs_used && hz.id_valid) begin
        hit_a = 1'b1;
        ya_i  = i;
        ld_a  = sb_q[i].is_load;
      end
      if (sb_q[i].valid && (sb_q[i].addr == MAX_AW'(rt_addr)) &&
          hz.id_rt_used && hz.id_valid) begin
        hit_b = 1'b1;
        yb_i  = i;
        ld_b  = sb_q[i].is_load;
      end
    end
  end

  // RAW stall per source. With forwarding only a load still in EX cannot be
  // bypassed; without it anything short of WB (regfile write-through) stalls.
  always_comb begin
    stall_a = 1'b0;
    stall_b = 1'b0;
    if (FWD_EN != 0) begin
      stall_a = hit_a && (ya_i == 0) && ld_a;
      stall_b = hit_b && (yb_i == 0) && ld_b;
    end else begin
      stall_a = hit_a && (ya_i < DEPTH - 1);
      stall_b = hit_b && (yb_i < DEPTH - 1);
    end
    raw_stall = stall_a || stall_b;
  end

  // Forwarding selects: stage index + 1 of the youngest producer, regfile
  // when stalling, in legacy mode or while reset is held.
  always_comb begin
    fwd_a_sel = SEL_W'(FWD_RF);
    fwd_b_sel = SEL_W'(FWD_RF);
    if ((FWD_EN != 0) && rst && !raw_stall) begin
      if (hit_a) fwd_a_sel = SEL_W'(stage_to_sel(ya_i));
      if (hit_b) fwd_b_sel = SEL_W'(stage_to_sel(yb_i));
    end
  end

  // Priority resolution: freeze beats redirect/flush beats RAW stall.
  always_comb begin
    redir_acc = !hz.mem_busy && (hz.redirect || pend_q);
    if (hz.mem_busy)                                     state = FREEZE;
    else if (hz.redirect || pend_q || (fcnt_q != '0))    state = FLUSH;
    else if (raw_stall)                                  state = RAW_STALL;
    else                                                 state = RUN;
  end

  // Control outputs and next state for scoreboard, pending flag and flush
  // counter; outputs fall back to free-running values while reset is held.
  always_comb begin
    sb_d         = sb_q;
    pend_d       = pend_q;
    fcnt_d       = fcnt_q;
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    unique case (state)
      FREEZE: begin
        pc_we    = 1'b0;
        if_id_we = 1'b0;
        if (hz.redirect) pend_d = 1'b1;
      end
      FLUSH: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        if (redir_acc) begin
          pend_d = 1'b0;
          fcnt_d = FCNT_W'(FLUSH_CYCLES - 1);
        end else begin
          fcnt_d = fcnt_q - FCNT_W'(1);
        end
        for (int i = DEPTH - 1; i > 0; i--) sb_d[i] = sb_q[i-1];
        sb_d[0] = SB_EMPTY;
      end
      RAW_STALL: begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_bubble = 1'b1;
        for (int i = DEPTH - 1; i > 0; i--) sb_d[i] = sb_q[i-1];
        sb_d[0] = SB_EMPTY;
      end
      RUN: begin
        for (int i = DEPTH - 1; i > 0; i--) sb_d[i] = sb_q[i-1];
        sb_d[0].valid   = hz.id_valid && hz.id_wr_en;
        sb_d[0].addr    = MAX_AW'(wr_addr);
        sb_d[0].is_load = hz.id_is_load;
      end
    endcase
    if (!rst) begin
      pc_we        = 1'b1;
      if_id_we     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
    end
  end

  // Scoreboard, pending redirect and flush counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) sb_q[i] <= SB_EMPTY;
      pend_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) sb_q[i] <= sb_d[i];
      pend_q <= pend_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign stall_inc = rst && (state == RAW_STALL);
  assign flush_inc = rst && redir_acc;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (hz.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .cnt (hz.flush_cnt)
  );

  assign hz.pc_we        = pc_we;
  assign hz.if_id_we     = if_id_we;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_bubble = id_ex_bubble;
  assign hz.fwd_a_sel    = fwd_a_sel;
  assign hz.fwd_b_sel    = fwd_b_sel;

endmodule
